// File: rtl/threefish_pkg.sv
// rtl/threefish_pkg.sv - shared Threefish-1024 constants and key schedule state type
//
// Purpose: constants shared by the key extender and the key schedule, plus the
//          schedule FSM state encoding.
// Ports:   none (package).

package threefish_pkg;

   localparam int WORD_W          = 64;
   localparam int NUM_STATE_WORDS = 16;
   localparam int NUM_KEY_WORDS   = 17;
   localparam int NUM_SUBKEYS     = 21;

   // Key parity seed; the extended key's word 16 is C240 xor all key words.
   localparam logic [63:0] C240 = 64'h1BD1_1BDA_A9FC_1A22;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ks_state_e;

endpackage

// File: rtl/threefish_key_schedule.sv
// rtl/threefish_key_schedule.sv - sequential Threefish-1024 subkey generator
//
// Purpose: latches the 17-word extended key and the tweak, then presents the
//          21 subkeys one per valid/ready handshake.
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   load_valid_i/_ready_o load handshake for key_i (17 x 64) and tweak_i (2 x 64)
//   sk_valid_o/sk_ready_i subkey handshake
//   subkey_o              16 x 64 subkey, word i at [64i+63:64i]
//   sk_idx_o              subkey index s
//   sk_last_o             high with sk_valid_o on s = NUM_SUBKEYS-1
//   done_o                one-cycle pulse after the last subkey is accepted

module threefish_key_schedule
   import threefish_pkg::*;
#(
   parameter int WORD_W      = 64,   // only 64 is supported
   parameter int NUM_SUBKEYS = 21
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic                              load_valid_i,
   output logic                              load_ready_o,
   input  logic [NUM_KEY_WORDS*WORD_W-1:0]   key_i,
   input  logic [2*WORD_W-1:0]               tweak_i,
   output logic                              sk_valid_o,
   input  logic                              sk_ready_i,
   output logic [NUM_STATE_WORDS*WORD_W-1:0] subkey_o,
   output logic [4:0]                        sk_idx_o,
   output logic                              sk_last_o,
   output logic                              done_o
);

   ks_state_e         state_q, state_d;
   logic [WORD_W-1:0] kreg_q [NUM_KEY_WORDS];
   logic [WORD_W-1:0] kreg_d [NUM_KEY_WORDS];
   logic [WORD_W-1:0] treg_q [3];
   logic [WORD_W-1:0] treg_d [3];
   logic [4:0]        s_q, s_d;
   logic              done_q, done_d;
   logic              last_s;

   assign last_s = (s_q == 5'(NUM_SUBKEYS - 1));

   always_comb begin
      state_d      = state_q;
      kreg_d       = kreg_q;
      treg_d       = treg_q;
      s_d          = s_q;
      done_d       = 1'b0;
      load_ready_o = 1'b0;
      sk_valid_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            load_ready_o = 1'b1;
            if (load_valid_i) begin
               for (int j = 0; j < NUM_KEY_WORDS; j++) begin
                  kreg_d[j] = key_i[j*WORD_W +: WORD_W];
               end
               treg_d[0] = tweak_i[WORD_W-1:0];
               treg_d[1] = tweak_i[2*WORD_W-1:WORD_W];
               treg_d[2] = tweak_i[WORD_W-1:0] ^ tweak_i[2*WORD_W-1:WORD_W];
               s_d       = 5'd0;
               state_d   = RUN;
            end
         end
         RUN: begin
            sk_valid_o = 1'b1;
            if (sk_ready_i) begin
               // Rotating the registers down one word per subkey yields
               // k[(s+i) mod 17] and t[(s+i-13) mod 3] at fixed word positions.
               for (int j = 0; j < NUM_KEY_WORDS; j++) begin
                  kreg_d[j] = kreg_q[(j + 1) % NUM_KEY_WORDS];
               end
               for (int j = 0; j < 3; j++) begin
                  treg_d[j] = treg_q[(j + 1) % 3];
               end
               if (last_s) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         for (int j = 0; j < NUM_KEY_WORDS; j++) begin
            kreg_q[j] <= '0;
         end
         for (int j = 0; j < 3; j++) begin
            treg_q[j] <= '0;
         end
         s_q    <= 5'd0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         kreg_q  <= kreg_d;
         treg_q  <= treg_d;
         s_q     <= s_d;
         done_q  <= done_d;
      end
   end

   // Injection adders: the only arithmetic between the registers and subkey_o.
   always_comb begin
      subkey_o = '0;
      for (int i = 0; i < 13; i++) begin
         subkey_o[i*WORD_W +: WORD_W] = kreg_q[i];
      end
      subkey_o[13*WORD_W +: WORD_W] = kreg_q[13] + treg_q[0];
      subkey_o[14*WORD_W +: WORD_W] = kreg_q[14] + treg_q[1];
      subkey_o[15*WORD_W +: WORD_W] = kreg_q[15] + {{(WORD_W-5){1'b0}}, s_q};
   end

   assign sk_idx_o  = s_q;
   assign sk_last_o = (state_q == RUN) && last_s;
   assign done_o    = done_q;

endmodule

// File: tb/tb_threefish_key_schedule.sv
// tb/tb_threefish_key_schedule.sv - directed self-checking bench for threefish_key_schedule

module tb_threefish_key_schedule;

   localparam logic [63:0] C240 = 64'h1BD1_1BDA_A9FC_1A22;

   logic           clk;
   logic           rst_n;
   logic           load_valid;
   logic           load_ready;
   logic [1087:0]  key;
   logic [127:0]   tweak;
   logic           sk_valid;
   logic           sk_ready;
   logic [1023:0]  subkey;
   logic [4:0]     sk_idx;
   logic           sk_last;
   logic           done;

   int checks = 0;
   int errors = 0;

   threefish_key_schedule #(.WORD_W(64), .NUM_SUBKEYS(21)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .load_valid_i (load_valid),
      .load_ready_o (load_ready),
      .key_i        (key),
      .tweak_i      (tweak),
      .sk_valid_o   (sk_valid),
      .sk_ready_i   (sk_ready),
      .subkey_o     (subkey),
      .sk_idx_o     (sk_idx),
      .sk_last_o    (sk_last),
      .done_o       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference subkey straight from the Threefish definition (indexed, not rotated).
   function automatic logic [1023:0] ref_sk(input logic [1087:0] k, input logic [127:0] tw, input int s);
      logic [63:0] t [3];
      logic [1023:0] r;
      t[0] = tw[63:0];
      t[1] = tw[127:64];
      t[2] = t[0] ^ t[1];
      for (int i = 0; i < 16; i++) begin
         r[i*64 +: 64] = k[((s + i) % 17)*64 +: 64];
      end
      r[13*64 +: 64] = r[13*64 +: 64] + t[s % 3];
      r[14*64 +: 64] = r[14*64 +: 64] + t[(s + 1) % 3];
      r[15*64 +: 64] = r[15*64 +: 64] + 64'(s);
      return r;
   endfunction

   function automatic logic [1087:0] pattern_key(input logic [63:0] base);
      logic [1087:0] k;
      for (int j = 0; j < 17; j++) begin
         k[j*64 +: 64] = base + 64'(j * 3 + 1);
      end
      return k;
   endfunction

   // Drives a load and returns at the falling edge where subkey 0 is presented.
   task automatic do_load(input logic [1087:0] k, input logic [127:0] tw);
      @(negedge clk);
      load_valid = 1'b1;
      key        = k;
      tweak      = tw;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      sk_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (load_ready !== 1'b1 || sk_valid !== 1'b0 || sk_last !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b valid=%b last=%b done=%b, need 1 0 0 0", load_ready, sk_valid, sk_last, done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (sk_idx !== 5'd0 || subkey !== '0) begin
         errors++;
         $display("FAIL reset_data: idx=%0d subkey=%h, need 0 and 0", sk_idx, subkey);
      end
   endtask

   task automatic test_zero_key;
      logic [1087:0] k;
      logic [1023:0] exp;
      k = '0;
      k[16*64 +: 64] = C240;
      sk_ready = 1'b1;
      do_load(k, '0);
      checks++;
      if (subkey !== '0 || sk_idx !== 5'd0 || sk_valid !== 1'b1 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_s0: subkey=%h idx=%0d valid=%b ready=%b, need 0 0 1 0", subkey, sk_idx, sk_valid, load_ready);
      end
      @(negedge clk);
      exp = '0;
      exp[15*64 +: 64] = 64'h1BD1_1BDA_A9FC_1A23;
      checks++;
      if (subkey !== exp) begin
         errors++;
         $display("FAIL zero_s1: got %h need %h", subkey, exp);
      end
      @(negedge clk);
      exp = '0;
      exp[14*64 +: 64] = 64'h1BD1_1BDA_A9FC_1A22;
      exp[15*64 +: 64] = 64'd2;
      checks++;
      if (subkey !== exp) begin
         errors++;
         $display("FAIL zero_s2: got %h need %h", subkey, exp);
      end
      repeat (18) @(negedge clk);
      checks++;
      if (sk_idx !== 5'd20 || sk_last !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL zero_last: idx=%0d last=%b done=%b, need 20 1 0", sk_idx, sk_last, done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || load_ready !== 1'b1 || sk_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done=%b ready=%b valid=%b, need 1 1 0", done, load_ready, sk_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_done_pulse: done=%b need 0", done);
      end
   endtask

   task automatic test_tweak;
      logic [1087:0] k;
      bit ok;
      k = '0;
      k[16*64 +: 64] = C240;
      sk_ready = 1'b1;
      do_load(k, {64'd2, 64'd1});
      checks++;
      if (subkey[13*64 +: 64] !== 64'd1 || subkey[14*64 +: 64] !== 64'd2 || subkey[15*64 +: 64] !== 64'd0) begin
         errors++;
         $display("FAIL tweak_s0: w13..15=%h %h %h need 1 2 0", subkey[13*64 +: 64], subkey[14*64 +: 64], subkey[15*64 +: 64]);
      end
      @(negedge clk);
      checks++;
      if (subkey[13*64 +: 64] !== 64'd2 || subkey[14*64 +: 64] !== 64'd3 || subkey[15*64 +: 64] !== 64'h1BD1_1BDA_A9FC_1A23) begin
         errors++;
         $display("FAIL tweak_s1: w13..15=%h %h %h need 2 3 1bd11bdaa9fc1a23", subkey[13*64 +: 64], subkey[14*64 +: 64], subkey[15*64 +: 64]);
      end
      @(negedge clk);
      checks++;
      if (subkey[13*64 +: 64] !== 64'd3) begin
         errors++;
         $display("FAIL tweak_s2: w13=%h need 3", subkey[13*64 +: 64]);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tweak_drain: done not seen within 40 cycles");
      end
   endtask

   task automatic test_adder_wrap;
      logic [1087:0] k;
      bit ok;
      k = '0;
      k[15*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
      k[16*64 +: 64] = 64'hE42E_E425_5603_E5DD;
      sk_ready = 1'b1;
      do_load(k, '0);
      checks++;
      if (subkey[15*64 +: 64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_s0: w15=%h need ffffffffffffffff", subkey[15*64 +: 64]);
      end
      repeat (17) @(negedge clk);
      checks++;
      if (sk_idx !== 5'd17 || subkey[15*64 +: 64] !== 64'h10) begin
         errors++;
         $display("FAIL wrap_s17: idx=%0d w15=%h need 17 0000000000000010", sk_idx, subkey[15*64 +: 64]);
      end
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_drain: done not seen within 40 cycles");
      end
   endtask

   task automatic test_backpressure;
      logic [1087:0] k;
      logic [127:0]  tw;
      logic [1023:0] exp7;
      bit ok;
      k  = pattern_key(64'hA000_0000_0000_0000);
      tw = {64'h0F0F_0000_1111_2222, 64'h3333_4444_5555_6666};
      exp7 = ref_sk(k, tw, 7);
      sk_ready = 1'b1;
      do_load(k, tw);
      repeat (7) @(negedge clk);
      sk_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (subkey !== exp7 || sk_idx !== 5'd7 || sk_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d: idx=%0d valid=%b subkey=%h need idx 7 subkey %h", c, sk_idx, sk_valid, subkey, exp7);
         end
         @(negedge clk);
      end
      checks++;
      if (sk_idx !== 5'd7) begin
         errors++;
         $display("FAIL bp_no_advance: idx=%0d need 7", sk_idx);
      end
      sk_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (sk_idx !== 5'd8 || subkey !== ref_sk(k, tw, 8)) begin
         errors++;
         $display("FAIL bp_s8: idx=%0d subkey=%h need 8 %h", sk_idx, subkey, ref_sk(k, tw, 8));
      end
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_drain: done not seen within 40 cycles");
      end
   endtask

   task automatic test_load_in_run;
      logic [1087:0] ka;
      logic [127:0]  tw;
      bit ok;
      ka = pattern_key(64'h0123_4567_89AB_CDEF);
      tw = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};
      sk_ready = 1'b1;
      do_load(ka, tw);
      repeat (4) @(negedge clk);
      load_valid = 1'b1;
      key        = pattern_key(64'h5555_0000_AAAA_0000);
      tweak      = '1;
      checks++;
      if (load_ready !== 1'b0 || sk_idx !== 5'd4) begin
         errors++;
         $display("FAIL run_load_ready: ready=%b idx=%0d need 0 4", load_ready, sk_idx);
      end
      @(negedge clk);
      load_valid = 1'b0;
      for (int s = 5; s < 21; s++) begin
         checks++;
         if (sk_idx !== 5'(s) || subkey !== ref_sk(ka, tw, s)) begin
            errors++;
            $display("FAIL run_load_s%0d: idx=%0d subkey=%h need %h", s, sk_idx, subkey, ref_sk(ka, tw, s));
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL run_load_done: done=%b need 1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset;
      logic [1087:0] k;
      logic [127:0]  tw;
      bit ok;
      k  = pattern_key(64'h7777_0000_0000_0000);
      tw = {64'd9, 64'd5};
      sk_ready = 1'b1;
      do_load(k, tw);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sk_valid !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL areset_drop: valid=%b ready=%b need 0 1", sk_valid, load_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1 || sk_idx !== 5'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL areset_idle: ready=%b idx=%0d done=%b need 1 0 0", load_ready, sk_idx, done);
      end
      do_load(k, tw);
      checks++;
      if (sk_idx !== 5'd0 || sk_valid !== 1'b1 || subkey !== ref_sk(k, tw, 0)) begin
         errors++;
         $display("FAIL areset_reload: idx=%0d valid=%b subkey=%h need 0 1 %h", sk_idx, sk_valid, subkey, ref_sk(k, tw, 0));
      end
      drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL areset_drain: done not seen within 40 cycles");
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      key        = '0;
      tweak      = '0;
      sk_ready   = 1'b0;
      test_reset();
      test_zero_key();
      test_tweak();
      test_adder_wrap();
      test_backpressure();
      test_load_in_run();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/threefish_key_schedule.md
# threefish_key_schedule

Sequential Threefish-1024 subkey generator sitting directly downstream of the key extender. It accepts the 17-word extended key (16 key words plus parity word) and the 128-bit tweak, then emits the 21 subkeys (s = 0..20) one per handshake to the round datapath. Each subkey word is a 64-bit modular sum of a rotated key word and the tweak/counter injections.

## Interface
Parameters:
- WORD_W, 64, word width in bits; the block supports only 64.
- NUM_SUBKEYS, 21, number of subkeys per load (s = 0..NUM_SUBKEYS-1).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset; one clock, asynchronous, active-low.
- load_valid_i  in  1  key/tweak load request.
- load_ready_o  out  1  high when the block is IDLE and can accept a load.
- key_i  in  1088  extended key; word j at [64j+63:64j], j = 0..16, word 16 is parity.
- tweak_i  in  128  t0 at [63:0], t1 at [127:64].
- sk_valid_o  out  1  subkey_o is valid.
- sk_ready_i  in  1  consumer accepts the current subkey.
- subkey_o  out  1024  subkey word i at [64i+63:64i], i = 0..15.
- sk_idx_o  out  5  current s.
- sk_last_o  out  1  high with sk_valid_o when s = 20.
- done_o  out  1  one-cycle pulse after subkey 20 is accepted.

## Operation
- States: IDLE, RUN.
- IDLE: load_ready_o=1 and sk_valid_o=0. When load_valid_i=1:
  - kreg <= key_i (17 words).
  - treg <= {t0, t1, t0^t1}.
  - s <= 0.
  - Next state RUN.
- RUN: sk_valid_o=1, load_ready_o=0. subkey_o is combinational from the registers:
  - word i = kreg[i] for i = 0..12.
  - word 13 = kreg[13] + treg[0].
  - word 14 = kreg[14] + treg[1].
  - word 15 = kreg[15] + zero-extended s.
  - Arithmetic is modulo 2^64; carry out is discarded.
- Register update on acceptance (sk_valid_o & sk_ready_i):
  - kreg rotates down one word: kreg[j] <= kreg[(j+1) mod 17].
  - treg rotates: treg[j] <= treg[(j+1) mod 3].
  - s <= s+1.
- These rotations implement k[(s+i) mod 17] and t[(s+i-13) mod 3] without wide muxes.
- Accepting at s=20: next state IDLE, done_o=1 for one cycle, and s is not incremented.
- Backpressure: with sk_ready_i=0, all registers hold and subkey_o, sk_idx_o and sk_last_o stay stable.
- load_valid_i in RUN is ignored; there is no abort path.
- The block does not check the parity word; key_i is used as given.
- Reset values: state IDLE, kreg=0, treg=0, s=0, load_ready_o=1, sk_valid_o=0, sk_last_o=0, done_o=0, sk_idx_o=0. subkey_o is then the combinational function of the zeroed registers, i.e. 0.
- Reset asserted mid-RUN returns the block to IDLE asynchronously. The partially consumed schedule is lost.

## Timing
- Load accepted at edge N; subkey 0 is valid in the cycle after edge N.
- With sk_ready_i held high, one subkey per cycle. 21 cycles RUN, done_o in the cycle after the final acceptance, load_ready_o high in that same cycle.
- Minimum load-to-load interval: 22 cycles.
- Critical path: one 64-bit adder from registers to subkey_o. The consumer registers subkey_o.

## Structure
- Shared package threefish_pkg holds:
  - WORD_W=64, NUM_STATE_WORDS=16, NUM_KEY_WORDS=17, NUM_SUBKEYS=21.
  - Constant C240 = 64'h1BD11BDAA9FC1A22 (also used by the extender).
  - The state enum {IDLE, RUN}.
- No sub-module is required. The three injection adders stay inline.

## Test plan
- Reset then zero key/tweak: load key_i = extended zero key (word 16 = 0x1BD11BDAA9FC1A22), tweak_i = 0, sk_ready_i = 1. Required:
  - s=0: subkey all zero.
  - s=1: word 15 = 0x1BD11BDAA9FC1A23, other words 0.
  - s=2: word 14 = 0x1BD11BDAA9FC1A22 and word 15 = 2.
  - done_o pulses one cycle after s=20 is accepted.
- Tweak injection: zero key words 0..15 (word 16 = C240), t0 = 1, t1 = 2. Required:
  - s=0: words 13/14/15 = 1/2/0.
  - s=1: words 13/14/15 = 2/3/C240+1.
  - s=2: word 13 = 3.
- Adder wrap: key word 15 = 0xFFFFFFFFFFFFFFFF, all else 0 (word 16 = 0xE42EE42556 03E5DD), tweak 0. Required:
  - s=0: word 15 = 0xFFFFFFFFFFFFFFFF.
  - s=17: word 15 = 0x0000000000000010 (carry dropped).
- Backpressure: hold sk_ready_i low 5 cycles at s=7. Required: subkey_o and sk_idx_o = 7 stable throughout; s=8 is presented only after acceptance.
- Load in RUN: pulse load_valid_i at s=4 with a different key. Required: ignored, load_ready_o = 0, and the schedule completes with the original key.
- Async reset at s=10: assert rst_n_i low mid-cycle. Required: sk_valid_o drops immediately; after release load_ready_o=1 and a new load restarts at s=0.
